quad_decoder: RTL and testbench
===============================

Name: quad_decoder

Overview:
- Quadrature (A/B) decoder with an up/down position counter.
- Sits between the encoder pins and the counter datapath; it is the source side of the up/down count interface.
- Synchronizes and filters the raw A/B pins, decodes every valid Gray-code transition into one up or one down step (x4 decoding), and keeps a wrapping position count.
- Flags illegal double-bit transitions.

Parameters:
- WIDTH, 16, width of the position counter.
- SYNC_STAGES, 2, number of flip-flops in each pin synchronizer (legal range 2..4).
- FILTER_LEN, 3, number of consecutive cycles a synchronized bit must differ from its filtered value before the filtered value takes the new level (legal range 1..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- quad_a  in  1  raw encoder phase A; asynchronous to clk.
- quad_b  in  1  raw encoder phase B; asynchronous to clk.
- clr  in  1  synchronous clear of count and err.
- count  out  WIDTH  position count, modulo 2^WIDTH.
- dir  out  1  direction of the last valid step (1 = up, 0 = down).
- step  out  1  one-cycle pulse on each valid step.
- err  out  1  sticky illegal-transition flag.

Behaviour:
- Reset (reset=0, asynchronous): count=0, dir=0, step=0, err=0, synchronizers=0, filter counters=0, FSM=ST_INIT.
- Synchronizer: each pin passes through SYNC_STAGES flops, giving sync_a and sync_b.
- Filter, per bit and independent for A and B:
  - While sync differs from filt, the bit's counter increments each cycle.
  - On the edge where the counter would reach FILTER_LEN, filt takes sync and the counter returns to 0.
  - Any cycle with sync == filt resets the counter to 0.
- FSM states:
  - ST_INIT: wait SYNC_STAGES cycles after reset release, then load filt and prev directly from sync without counting, and go to ST_RUN. This prevents spurious steps when pins are nonzero at reset.
  - ST_RUN: each cycle compare cur={filt_a,filt_b} with prev; prev<=cur.
- Decode in ST_RUN:
  - Up sequence: 00->10->11->01->00. Each such transition gives count+1, dir=1, step=1 for one cycle.
  - Down sequence: reverse order. Each such transition gives count-1, dir=0, step=1.
  - cur==prev: no change, step=0.
  - Both bits changed (00<->11, 10<->01): err<=1 (sticky), count and dir unchanged, step=0.
- Arithmetic: count wraps modulo 2^WIDTH; up from all-ones gives 0, down from 0 gives all-ones. No saturation.
- Latency: if edge k is the first edge at which the first synchronizer flop captures a new pin level, the new count is visible after edge k + SYNC_STAGES + FILTER_LEN. The step pulse is aligned with the count update.
- Pin pulses shorter than FILTER_LEN cycles after synchronization are rejected with no count change.
- clr=1:
  - count<=0 and err<=0.
  - Clear has priority over a simultaneous step: count ends at 0, but step and dir still reflect the decoded step.
  - clr=1 in ST_INIT is ignored.
- Reset asserted mid-operation: immediate return to reset values and ST_INIT. A partial filter count is discarded.
- All outputs are registered.

Decomposition:
- Shared package quad_pkg holds:
  - FSM state encoding (ST_INIT, ST_RUN);
  - named 2-bit phase constants PH_00, PH_10, PH_11, PH_01;
  - a next-up/next-down lookup function.
- One natural sub-module, quad_sync_filter: one bit's synchronizer plus filter, parameterised by SYNC_STAGES and FILTER_LEN, instantiated twice.

Test Plan:
- Reset with quad_a=1, quad_b=1, release, hold 20 cycles -> count=0, step never 1, err=0.
- 5 full up cycles (20 transitions, each level held 8 cycles), default params -> count=20, dir=1, exactly 20 step pulses; first step appears 5 edges after the first capture edge.
- From count=0, 3 down transitions -> count=16'hFFFD, dir=0. Then 3 up transitions -> count=0.
- Glitch: a 2-cycle pulse on quad_a with FILTER_LEN=3 -> count unchanged, no step. A 4-cycle pulse -> one up step then one down step, count back to its original value.
- Illegal 00->11 (both pins switch together) -> err=1, count unchanged. Assert clr one cycle -> err=0, count=0.
- Assert reset mid-sequence at count=7 -> outputs are 0 asynchronously (before the next clock edge). Resume stepping -> counting restarts from 0 with no spurious step.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: FSM states, Gray-code phase
// constants and the phase-sequence lookup used by the step decoder.
package quad_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } quad_state_e;

   // Phases are written {a, b}; the up sequence is 00 -> 10 -> 11 -> 01 -> 00.
   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_10 = 2'b10;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_01 = 2'b01;

   function automatic logic [1:0] phase_next(input logic [1:0] ph, input logic up);
      logic [1:0] nxt;
      case (ph)
         PH_00:   nxt = up ? PH_10 : PH_01;
         PH_10:   nxt = up ? PH_11 : PH_00;
         PH_11:   nxt = up ? PH_01 : PH_10;
         default: nxt = up ? PH_00 : PH_11;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// One encoder pin: a SYNC_STAGES-deep synchronizer followed by a level filter
// that accepts a new level only after FILTER_LEN consecutive differing cycles.
module quad_sync_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic i_pin,
   input  logic i_load,
   output logic o_sync,
   output logic o_filt
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_filt;
   logic [3:0]             r_cnt;
   logic                   w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      end
   end

   // i_load seeds the filter straight from the synchronizer at start-up.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_filt <= 1'b0;
         r_cnt  <= '0;
      end else if (i_load) begin
         r_filt <= w_sync;
         r_cnt  <= '0;
      end else if (w_sync != r_filt) begin
         if (r_cnt == 4'(FILTER_LEN - 1)) begin
            r_filt <= w_sync;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + 4'd1;
         end
      end else begin
         r_cnt <= '0;
      end
   end

   assign o_sync = w_sync;
   assign o_filt = r_filt;

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: filtered A/B phases drive a wrapping up/down position
// counter with a one-cycle step pulse, last direction and sticky error flag.
module quad_decoder #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             quad_a,
   input  logic             quad_b,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             step,
   output logic             err
);

   import quad_pkg::*;

   quad_state_e      r_state;
   quad_state_e      w_state_nxt;
   logic             w_load;
   logic [2:0]       r_init_cnt;
   logic             w_init_done;
   logic             w_sync_a, w_sync_b;
   logic             w_filt_a, w_filt_b;
   logic [1:0]       w_cur;
   logic [1:0]       r_prev;
   logic             w_up, w_down, w_illegal;
   logic [WIDTH-1:0] r_count;
   logic             r_dir, r_step, r_err;

   quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
      .clk(clk), .reset(reset), .i_pin(quad_a), .i_load(w_load),
      .o_sync(w_sync_a), .o_filt(w_filt_a)
   );

   quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
      .clk(clk), .reset(reset), .i_pin(quad_b), .i_load(w_load),
      .o_sync(w_sync_b), .o_filt(w_filt_b)
   );

   // Start-up waits for the synchronizers to hold real pin levels before seeding.
   assign w_init_done = (r_init_cnt == 3'(SYNC_STAGES));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_INIT;
         r_init_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_INIT && !w_init_done) begin
            r_init_cnt <= r_init_cnt + 3'd1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         ST_INIT: begin
            if (w_init_done) begin
               w_load      = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   assign w_cur     = {w_filt_a, w_filt_b};
   assign w_up      = (w_cur == phase_next(r_prev, 1'b1));
   assign w_down    = (w_cur == phase_next(r_prev, 1'b0));
   assign w_illegal = (w_cur == ~r_prev);

   // Clear overrides count and err, but step/dir still report the decoded step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prev  <= PH_00;
         r_count <= '0;
         r_dir   <= 1'b0;
         r_step  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_step <= 1'b0;
         if (w_load) begin
            r_prev <= {w_sync_a, w_sync_b};
         end else if (r_state == ST_RUN) begin
            r_prev <= w_cur;
            if (w_up) begin
               r_count <= r_count + 1'b1;
               r_dir   <= 1'b1;
               r_step  <= 1'b1;
            end else if (w_down) begin
               r_count <= r_count - 1'b1;
               r_dir   <= 1'b0;
               r_step  <= 1'b1;
            end else if (w_illegal) begin
               r_err <= 1'b1;
            end
            if (clr) begin
               r_count <= '0;
               r_err   <= 1'b0;
            end
         end
      end
   end

   assign count = r_count;
   assign dir   = r_dir;
   assign step  = r_step;
   assign err   = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed table of phase transitions, glitch/illegal/
// reset sequences, and randomized moves checked against a phase-index model.
module tb_quad_decoder;

   typedef struct {
      logic        a;
      logic        b;
      logic        clr_first;
      logic [15:0] exp_count;
      logic        exp_dir;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        quad_a, quad_b, clr;
   logic [15:0] count;
   logic        dir, step, err;

   int n_cmp = 0;
   int n_bad = 0;
   int step_cnt = 0;

   // Model: position in the up sequence, expected count/dir, expected pulses.
   logic [1:0]  ph_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
   int          idx;
   logic [15:0] mc;
   logic        md;
   int          ms;

   vec_t vecs [26];

   quad_decoder #(.WIDTH(16), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
      .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b), .clr(clr),
      .count(count), .dir(dir), .step(step), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (step === 1'b1) step_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Caller is at a negedge; pins change now and are held for hold cycles.
   task automatic drive(input logic a, input logic b, input int hold);
      quad_a = a;
      quad_b = b;
      repeat (hold) @(negedge clk);
   endtask

   task automatic move(input int kind, input int hold);
      if (kind == 0) begin
         idx = (idx + 1) % 4;
         mc  = mc + 16'd1;
         md  = 1'b1;
      end else begin
         idx = (idx + 3) % 4;
         mc  = mc - 16'd1;
         md  = 1'b0;
      end
      ms++;
      drive(ph_seq[idx][1], ph_seq[idx][0], hold);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 20; i++) begin
         vecs[i] = '{ph_seq[(i + 1) % 4][1], ph_seq[(i + 1) % 4][0], 1'b0, 16'(i + 1), 1'b1};
      end
      vecs[20] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0};
      vecs[21] = '{1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0};
      vecs[22] = '{1'b1, 1'b0, 1'b0, 16'hFFFD, 1'b0};
      vecs[23] = '{1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b1};
      vecs[24] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1};
      vecs[25] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};

      // Reset with both pins high: no spurious step after release.
      reset = 1'b0; quad_a = 1'b1; quad_b = 1'b1; clr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_count", 32'(count), 32'd0);
      check("rst_step", 32'(step), 32'd0);
      check("rst_dir", 32'(dir), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      check("pins11_count", 32'(count), 32'd0);
      check("pins11_steps", 32'(step_cnt), 32'd0);
      check("pins11_err", 32'(err), 32'd0);

      reset = 1'b0; quad_a = 1'b0; quad_b = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);

      // Directed table: 20 up steps, clear, 3 down (wrap), 3 up.
      for (int i = 0; i < 26; i++) begin
         if (vecs[i].clr_first) begin
            pulse_clr();
            check("tbl_clr_count", 32'(count), 32'd0);
         end
         if (i == 0) begin
            quad_a = vecs[i].a;
            quad_b = vecs[i].b;
            repeat (5) @(posedge clk);
            #1;
            check("lat_early_step", 32'(step), 32'd0);
            check("lat_early_count", 32'(count), 32'd0);
            @(posedge clk);
            #1;
            check("lat_step", 32'(step), 32'd1);
            check("lat_count", 32'(count), 32'd1);
            repeat (4) @(negedge clk);
         end else begin
            drive(vecs[i].a, vecs[i].b, 8);
         end
         check($sformatf("tbl_count_%0d", i), 32'(count), 32'(vecs[i].exp_count));
         check($sformatf("tbl_dir_%0d", i), 32'(dir), 32'(vecs[i].exp_dir));
         if (i == 19) check("tbl_steps20", 32'(step_cnt), 32'd20);
      end
      check("tbl_steps26", 32'(step_cnt), 32'd26);
      idx = 0; mc = 16'd0; md = 1'b1; ms = 26;

      // Glitches: 2-cycle pulse rejected, 4-cycle pulse gives up then down.
      drive(1'b1, 1'b0, 2);
      drive(1'b0, 1'b0, 12);
      check("glitch2_count", 32'(count), 32'd0);
      check("glitch2_steps", 32'(step_cnt), 32'(ms));
      drive(1'b1, 1'b0, 4);
      drive(1'b0, 1'b0, 12);
      ms += 2; md = 1'b0;
      check("glitch4_count", 32'(count), 32'd0);
      check("glitch4_steps", 32'(step_cnt), 32'(ms));
      check("glitch4_dir", 32'(dir), 32'd0);

      // Illegal double-bit transition 11 -> 00, then clear.
      move(0, 8);
      move(0, 8);
      drive(1'b0, 1'b0, 10);
      idx = 0;
      check("illegal_err", 32'(err), 32'd1);
      check("illegal_count", 32'(count), 32'd2);
      check("illegal_steps", 32'(step_cnt), 32'(ms));
      pulse_clr();
      mc = 16'd0;
      check("clr_err", 32'(err), 32'd0);
      check("clr_count", 32'(count), 32'd0);

      // Randomized moves against the model.
      for (int n = 0; n < 40; n++) begin
         int k;
         int h;
         k = $urandom_range(0, 2);
         h = $urandom_range(6, 12);
         if ($urandom_range(0, 9) == 0) begin
            pulse_clr();
            mc = 16'd0;
         end
         if (k < 2) move(k, h);
         else drive(ph_seq[idx][1], ph_seq[idx][0], h);
         check($sformatf("rnd_count_%0d", n), 32'(count), 32'(mc));
         check($sformatf("rnd_dir_%0d", n), 32'(dir), 32'(md));
      end
      check("rnd_steps", 32'(step_cnt), 32'(ms));
      check("rnd_err", 32'(err), 32'd0);

      // Reset mid-sequence at count 7: asynchronous clear, clean restart.
      pulse_clr();
      mc = 16'd0;
      for (int n = 0; n < 7; n++) move(0, 8);
      check("pre_rst_count", 32'(count), 32'd7);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_count", 32'(count), 32'd0);
      check("async_rst_dir", 32'(dir), 32'd0);
      check("async_rst_step", 32'(step), 32'd0);
      mc = 16'd0; md = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_count", 32'(count), 32'd0);
      check("post_rst_steps", 32'(step_cnt), 32'(ms));
      move(0, 8);
      move(0, 8);
      check("resume_count", 32'(count), 32'(mc));
      check("resume_dir", 32'(dir), 32'd1);
      check("resume_steps", 32'(step_cnt), 32'(ms));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
